// File: rtl/issue_queue_pkg.sv
// Shared types for the age-ordered issue queues: operand/entry layout,
// wake broadcast record, per-class default depths and the operand wake merge.
package issue_queue_pkg;

  localparam int unsigned IQ_PREG_W    = 6;
  localparam int unsigned IQ_DATA_W    = 32;
  localparam int unsigned IQ_PAYLOAD_W = 96;

  localparam int unsigned ALU_QUEUE_LEN    = 8;
  localparam int unsigned MEM_QUEUE_LEN    = 8;
  localparam int unsigned BRANCH_QUEUE_LEN = 4;
  localparam int unsigned MULT_QUEUE_LEN   = 4;

  typedef struct packed {
    logic                 rdy;
    logic [IQ_PREG_W-1:0] tag;
    logic [IQ_DATA_W-1:0] data;
  } iq_src_t;

  typedef struct packed {
    logic [IQ_PREG_W-1:0]    dst;
    iq_src_t                 src1;
    iq_src_t                 src2;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  localparam int unsigned IQ_ENTRY_W = $bits(iq_entry_t);

  typedef struct packed {
    logic                 valid;
    logic [IQ_PREG_W-1:0] tag;
    logic [IQ_DATA_W-1:0] data;
  } wake_req_t;

  // A broadcast only captures an operand that is still waiting.
  function automatic iq_src_t wake_src(input iq_src_t s, input logic hit,
                                       input logic [IQ_DATA_W-1:0] data);
    iq_src_t r;
    r = s;
    if (!s.rdy && hit) begin
      r.rdy  = 1'b1;
      r.data = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_wake_match.sv
// One operand tag against every wake broadcast; the lowest-numbered matching
// port supplies the data.
module iq_wake_match #(
  parameter int unsigned WAKE_NUM = 4,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned DATA_W   = 32
) (
  input  logic [PREG_W-1:0]                 tag_i,
  input  logic [WAKE_NUM-1:0]               wake_valid_i,
  input  logic [WAKE_NUM-1:0][PREG_W-1:0]   wake_tag_i,
  input  logic [WAKE_NUM-1:0][DATA_W-1:0]   wake_data_i,
  output logic                              hit_o,
  output logic [DATA_W-1:0]                 data_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    // Scan high to low so the lowest matching port is the last writer.
    for (int w = WAKE_NUM - 1; w >= 0; w--) begin
      if (wake_valid_i[w] && (wake_tag_i[w] == tag_i)) begin
        hit_o  = 1'b1;
        data_o = wake_data_i[w];
      end
    end
  end

endmodule

// File: rtl/age_issue_queue.sv
// Collapsing age-ordered issue queue: slot 0 is oldest, ready entries are
// offered oldest-first, issued entries collapse out and new writes append.
module age_issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned QUEUE_LEN = ALU_QUEUE_LEN,
  parameter int unsigned WRITE_NUM = 2,
  parameter int unsigned READ_NUM  = 1,
  parameter int unsigned WAKE_NUM  = 4,
  parameter int unsigned PREG_W    = IQ_PREG_W,
  parameter int unsigned DATA_W    = IQ_DATA_W,
  parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                flush,
  input  logic [WRITE_NUM-1:0]                wr_valid,
  input  iq_entry_t [WRITE_NUM-1:0]           wr_entry,
  output logic                                wr_ready,
  output logic [READ_NUM-1:0]                 rd_valid,
  output iq_entry_t [READ_NUM-1:0]            rd_entry,
  input  logic [READ_NUM-1:0]                 rd_ready,
  input  logic [WAKE_NUM-1:0]                 wake_valid,
  input  logic [WAKE_NUM-1:0][PREG_W-1:0]     wake_tag,
  input  logic [WAKE_NUM-1:0][DATA_W-1:0]     wake_data,
  output logic [$clog2(QUEUE_LEN+1)-1:0]      count,
  output logic                                full
);

  localparam int unsigned CNT_W = $clog2(QUEUE_LEN + 1);
  localparam int unsigned IDX_W = $clog2(QUEUE_LEN);
  localparam logic [CNT_W-1:0] WR_LIM  = CNT_W'(QUEUE_LEN - WRITE_NUM);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUEUE_LEN);

  iq_entry_t            ent_q  [QUEUE_LEN];
  iq_entry_t            ent_d  [QUEUE_LEN];
  iq_entry_t            ent_wk [QUEUE_LEN];
  iq_entry_t            wr_wk  [WRITE_NUM];
  logic [QUEUE_LEN-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [QUEUE_LEN-1:0] ent_rdy, iss_mask;
  int unsigned          ent_rank [QUEUE_LEN];

  assign count    = cnt_q;
  assign wr_ready = (cnt_q <= WR_LIM);
  assign full     = ~wr_ready;

  // Wake applied to stored entries (survivor view for the next edge).
  for (genvar i = 0; i < QUEUE_LEN; i++) begin : g_ent
    logic              h1, h2;
    logic [DATA_W-1:0] d1, d2;

    iq_wake_match #(.WAKE_NUM(WAKE_NUM), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_src1 (
      .tag_i(ent_q[i].src1.tag), .wake_valid_i(wake_valid), .wake_tag_i(wake_tag),
      .wake_data_i(wake_data), .hit_o(h1), .data_o(d1)
    );
    iq_wake_match #(.WAKE_NUM(WAKE_NUM), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_src2 (
      .tag_i(ent_q[i].src2.tag), .wake_valid_i(wake_valid), .wake_tag_i(wake_tag),
      .wake_data_i(wake_data), .hit_o(h2), .data_o(d2)
    );

    assign ent_wk[i]  = '{dst:     ent_q[i].dst,
                          src1:    wake_src(ent_q[i].src1, h1, d1),
                          src2:    wake_src(ent_q[i].src2, h2, d2),
                          payload: ent_q[i].payload};
    assign ent_rdy[i] = vld_q[i] & ent_q[i].src1.rdy & ent_q[i].src2.rdy;
  end

  // Incoming writes see the same broadcasts so they never miss a wake.
  for (genvar w = 0; w < WRITE_NUM; w++) begin : g_wr
    logic              h1, h2;
    logic [DATA_W-1:0] d1, d2;

    iq_wake_match #(.WAKE_NUM(WAKE_NUM), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_src1 (
      .tag_i(wr_entry[w].src1.tag), .wake_valid_i(wake_valid), .wake_tag_i(wake_tag),
      .wake_data_i(wake_data), .hit_o(h1), .data_o(d1)
    );
    iq_wake_match #(.WAKE_NUM(WAKE_NUM), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_src2 (
      .tag_i(wr_entry[w].src2.tag), .wake_valid_i(wake_valid), .wake_tag_i(wake_tag),
      .wake_data_i(wake_data), .hit_o(h2), .data_o(d2)
    );

    assign wr_wk[w] = '{dst:     wr_entry[w].dst,
                        src1:    wake_src(wr_entry[w].src1, h1, d1),
                        src2:    wake_src(wr_entry[w].src2, h2, d2),
                        payload: wr_entry[w].payload};
  end

  // Rank of each entry among ready entries below it (oldest-first select).
  always_comb begin
    int unsigned r;
    r = 0;
    for (int i = 0; i < QUEUE_LEN; i++) begin
      ent_rank[i] = r;
      if (ent_rdy[i]) r++;
    end
  end

  always_comb begin
    rd_valid = '0;
    rd_entry = '0;
    iss_mask = '0;
    for (int k = 0; k < READ_NUM; k++) begin
      for (int i = 0; i < QUEUE_LEN; i++) begin
        if (ent_rdy[i] && (ent_rank[i] == k)) begin
          rd_valid[k] = 1'b1;
          rd_entry[k] = ent_q[i];
          iss_mask[i] = rd_ready[k];
        end
      end
    end
  end

  // Collapse survivors toward slot 0, then append accepted writes in port order.
  always_comb begin
    int unsigned p;
    p = 0;
    for (int i = 0; i < QUEUE_LEN; i++) ent_d[i] = '0;
    for (int i = 0; i < QUEUE_LEN; i++) begin
      if (vld_q[i] && !iss_mask[i]) begin
        if (p < QUEUE_LEN) ent_d[IDX_W'(p)] = ent_wk[i];
        p++;
      end
    end
    if (wr_ready) begin
      for (int w = 0; w < WRITE_NUM; w++) begin
        if (wr_valid[w]) begin
          if (p < QUEUE_LEN) ent_d[IDX_W'(p)] = wr_wk[w];
          p++;
        end
      end
    end
    for (int j = 0; j < QUEUE_LEN; j++) vld_d[j] = (j < p);
    cnt_d = CNT_W'(p);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < QUEUE_LEN; i++) ent_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < QUEUE_LEN; i++) ent_q[i] <= ent_d[i];
    end
  end

  a_cnt_max: assert property (@(posedge clk) disable iff (!resetn) cnt_q <= CNT_MAX);
  a_iss_hs:  assert property (@(posedge clk) disable iff (!resetn)
                              $countones(iss_mask) == $countones(rd_valid & rd_ready));
  a_widths:  assert property (@(posedge clk) (PREG_W == IQ_PREG_W) && (DATA_W == IQ_DATA_W)
                              && (PAYLOAD_W == IQ_PAYLOAD_W));

  for (genvar k = 0; k < READ_NUM; k++) begin : g_rd_chk
    a_rd_known: assert property (@(posedge clk) disable iff (!resetn)
                                 rd_valid[k] |-> !$isunknown(rd_entry[k]));
  end

endmodule
